// File: rtl/prog_ram_pkg.sv
// Shared types and default sizing for the program RAM.
package prog_ram_pkg;

  localparam int DATA_W_DEF = 20;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Array index width; a single-word RAM still needs a 1-bit index.
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prog_ram_array.sv
// Word storage: one write port, one registered read port, no reset.
module prog_ram_array #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // The read returns the pre-write contents; the parent forwards same-address writes.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/prog_ram.sv
// Program RAM with a power-up clear sequence, write-first forwarding and range checks.
// Optional per-word even parity is enabled by defining PROG_RAM_PARITY_EN.
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef PROG_RAM_PARITY_EN
  input  logic              wr_perr_inj,
  output logic              rd_perr,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam int IDX_W = idx_bits(DEPTH);
`ifdef PROG_RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_oor_q, rd_oor_d;
  logic               fwd_q, fwd_d;
  logic               addr_err_q, addr_err_d;
  logic [WORD_W-1:0]  fwd_word_q, fwd_word_d;

  logic               rd_in, wr_in;
  logic [WORD_W-1:0]  wr_word, rd_word, arr_wdata, arr_rdata;
  logic               arr_we, arr_re;
  logic [IDX_W-1:0]   arr_waddr, arr_raddr;

  // Extra bit keeps DEPTH == 2**ADDR_W from truncating to zero.
  assign rd_in = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);
  assign wr_in = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);

`ifdef PROG_RAM_PARITY_EN
  assign wr_word = {(^wr_data) ^ wr_perr_inj, wr_data};
`else
  assign wr_word = wr_data;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_oor_d   = 1'b0;
    fwd_d      = 1'b0;
    fwd_word_d = wr_word;
    addr_err_d = 1'b0;
    arr_we     = 1'b0;
    arr_waddr  = cnt_q;
    arr_wdata  = '0;
    arr_re     = 1'b0;
    arr_raddr  = rd_addr[IDX_W-1:0];
    case (state_q)
      ST_CLEAR: begin
        arr_we = 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
        else                            cnt_d   = cnt_q + IDX_W'(1);
      end
      ST_RUN: begin
        arr_we     = wr_en && wr_in;
        arr_waddr  = wr_addr[IDX_W-1:0];
        arr_wdata  = wr_word;
        arr_re     = rd_en && rd_in;
        rd_valid_d = rd_en;
        rd_oor_d   = rd_en && !rd_in;
        fwd_d      = arr_re && arr_we && (rd_addr == wr_addr);
        addr_err_d = (rd_en && !rd_in) || (wr_en && !wr_in);
      end
      default: state_d = ST_CLEAR;
    endcase
    if (rst) arr_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_word_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_oor_q   <= rd_oor_d;
      fwd_q      <= fwd_d;
      fwd_word_q <= fwd_word_d;
      addr_err_q <= addr_err_d;
    end
  end

  prog_ram_array #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .raddr_i (arr_raddr),
    .rdata_o (arr_rdata)
  );

  // Outputs are forced quiet during the reset cycle itself, before the registers clear.
  assign rd_word  = fwd_q ? fwd_word_q : arr_rdata;
  assign rd_valid = rd_valid_q && !rst;
  assign rd_data  = (rd_valid && !rd_oor_q) ? rd_word[DATA_W-1:0] : '0;
  assign busy     = rst || (state_q == ST_CLEAR);
  assign addr_err = addr_err_q && !rst;

`ifdef PROG_RAM_PARITY_EN
  assign rd_perr = rd_valid && !rd_oor_q && ((^rd_word[DATA_W-1:0]) ^ rd_word[DATA_W]);
`endif

endmodule

// File: tb/tb_prog_ram.sv
// Directed self-checking bench for prog_ram (parity checks when PROG_RAM_PARITY_EN is defined).
module tb_prog_ram;

  localparam int DW    = 20;
  localparam int AW    = 16;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, busy, addr_err;
`ifdef PROG_RAM_PARITY_EN
  logic          wr_perr_inj = 1'b0;
  logic          rd_perr;
`endif

  int checks = 0;
  int errors = 0;

  prog_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`ifdef PROG_RAM_PARITY_EN
    .wr_perr_inj (wr_perr_inj),
    .rd_perr     (rd_perr),
`endif
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = a;
    step();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
  endtask

  // Counts edges from rst release until busy drops, checking requests stay ignored.
  task automatic count_clear(input string name);
    int n = 0;
    int bad = 0;
    do begin
      step();
      n++;
      if (rd_valid !== 1'b0 || addr_err !== 1'b0 || rd_data !== '0) bad++;
    end while (busy === 1'b1 && n < 1000);
    idle();
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, DEPTH);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s ignored_during_clear: %0d cycles had activity, expected 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 1'b1; rd_addr = 16'd3;
    wr_en = 1'b1; wr_addr = 16'd300; wr_data = 20'h11111;
    repeat (3) step();
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rd_valid=%b rd_data=%h addr_err=%b expected 1 0 0 0",
               busy, rd_valid, rd_data, addr_err);
    end
    // Keep requests active through the clear; writes to addr 7 must not land.
    rd_addr = 16'd300;
    wr_addr = 16'd7;
    rst = 1'b0;
    count_clear("initial_clear");
  endtask

  task automatic test_clear_readback();
    int bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a));
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== '0) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL clear_readback addr %0d: rd_valid=%b rd_data=%h expected 1 00000",
                   a, rd_valid, rd_data);
      end
    end
    idle();
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL no_read_idle: rd_valid=%b rd_data=%h expected 0 00000", rd_valid, rd_data);
    end
  endtask

  task automatic test_write_read();
    wr(16'd5, 20'hABCDE);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_only_valid: rd_valid=%b expected 0", rd_valid);
    end
    rd(16'd5);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 20'hABCDE) begin
      errors++;
      $display("FAIL write_read addr5: rd_valid=%b rd_data=%h expected 1 abcde", rd_valid, rd_data);
    end
    idle();
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL read_drop: rd_valid=%b rd_data=%h expected 0 00000", rd_valid, rd_data);
    end
  endtask

  task automatic test_write_first();
    rd_en = 1'b1; rd_addr = 16'd9;
    wr_en = 1'b1; wr_addr = 16'd9; wr_data = 20'h12345;
    step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 20'h12345) begin
      errors++;
      $display("FAIL write_first addr9: rd_valid=%b rd_data=%h expected 1 12345", rd_valid, rd_data);
    end
    rd(16'd9);
    checks++;
    if (rd_data !== 20'h12345) begin
      errors++;
      $display("FAIL write_first_stored addr9: rd_data=%h expected 12345", rd_data);
    end
    rd_en = 1'b1; rd_addr = 16'd10;
    wr_en = 1'b1; wr_addr = 16'd11; wr_data = 20'h54321;
    step();
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("FAIL no_false_forward addr10: rd_data=%h expected 00000", rd_data);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [4] = '{20'h10000, 20'h21111, 20'h32222, 20'h43333};
    for (int i = 0; i < 4; i++) wr(AW'(20 + i), exp[i]);
    for (int i = 0; i < 4; i++) begin
      rd(AW'(20 + i));
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin
        errors++;
        $display("FAIL back_to_back addr %0d: rd_valid=%b rd_data=%h expected 1 %h",
                 20 + i, rd_valid, rd_data, exp[i]);
      end
    end
    wr(16'd30, 20'hAAAAA);
    wr(16'd30, 20'h55555);
    rd(16'd30);
    checks++;
    if (rd_data !== 20'h55555) begin
      errors++;
      $display("FAIL overwrite addr30: rd_data=%h expected 55555", rd_data);
    end
    rd(16'd5);
    checks++;
    if (rd_data !== 20'hABCDE) begin
      errors++;
      $display("FAIL retain addr5: rd_data=%h expected abcde", rd_data);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    wr(16'd300, 20'h77777);
    checks++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_write_err: addr_err=%b expected 1", addr_err);
    end
    idle();
    step();
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_write_pulse: addr_err=%b expected 0", addr_err);
    end
    rd(16'd300);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== '0 || addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: rd_valid=%b rd_data=%h addr_err=%b expected 1 00000 1",
               rd_valid, rd_data, addr_err);
    end
    idle();
    step();
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_read_pulse: addr_err=%b expected 0", addr_err);
    end
    rd(16'd44);
    checks++;
    if (rd_data !== '0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL alias_addr44: rd_data=%h addr_err=%b expected 00000 0", rd_data, addr_err);
    end
    wr(16'd255, 20'hFEDCB);
    rd(16'd255);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 20'hFEDCB || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL top_addr255: rd_valid=%b rd_data=%h addr_err=%b expected 1 fedcb 0",
               rd_valid, rd_data, addr_err);
    end
    rd(16'd256);
    checks++;
    if (rd_data !== '0 || addr_err !== 1'b1) begin
      errors++;
      $display("FAIL edge_addr256: rd_data=%h addr_err=%b expected 00000 1", rd_data, addr_err);
    end
    rd(16'hFFFF);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== '0 || addr_err !== 1'b1) begin
      errors++;
      $display("FAIL max_addr: rd_valid=%b rd_data=%h addr_err=%b expected 1 00000 1",
               rd_valid, rd_data, addr_err);
    end
    idle();
  endtask

  task automatic test_rst_restart();
    rd_en = 1'b1; rd_addr = 16'd5;
    rst = 1'b1;
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL inflight_discard: rd_valid=%b rd_data=%h busy=%b expected 0 00000 1",
               rd_valid, rd_data, busy);
    end
    idle();
    rst = 1'b0;
    repeat (100) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_busy: busy=%b expected 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear("restart_clear");
    rd(16'd5);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      errors++;
      $display("FAIL cleared_addr5: rd_valid=%b rd_data=%h expected 1 00000", rd_valid, rd_data);
    end
    rd(16'd255);
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("FAIL cleared_addr255: rd_data=%h expected 00000", rd_data);
    end
    idle();
  endtask

`ifdef PROG_RAM_PARITY_EN
  task automatic test_parity();
    wr_perr_inj = 1'b1;
    wr(16'd3, 20'h00007);
    wr_perr_inj = 1'b0;
    rd(16'd3);
    checks++;
    if (rd_perr !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 20'h00007) begin
      errors++;
      $display("FAIL parity_inject addr3: rd_perr=%b rd_valid=%b rd_data=%h expected 1 1 00007",
               rd_perr, rd_valid, rd_data);
    end
    wr(16'd4, 20'h0000F);
    rd(16'd4);
    checks++;
    if (rd_perr !== 1'b0 || rd_data !== 20'h0000F) begin
      errors++;
      $display("FAIL parity_clean addr4: rd_perr=%b rd_data=%h expected 0 0000f", rd_perr, rd_data);
    end
    rd(16'd8);
    checks++;
    if (rd_perr !== 1'b0) begin
      errors++;
      $display("FAIL parity_cleared addr8: rd_perr=%b expected 0", rd_perr);
    end
    rd_en = 1'b1; rd_addr = 16'd6;
    wr_en = 1'b1; wr_addr = 16'd6; wr_data = 20'h00001; wr_perr_inj = 1'b1;
    step();
    wr_perr_inj = 1'b0;
    checks++;
    if (rd_perr !== 1'b1 || rd_data !== 20'h00001) begin
      errors++;
      $display("FAIL parity_forward addr6: rd_perr=%b rd_data=%h expected 1 00001", rd_perr, rd_data);
    end
    idle();
    step();
    checks++;
    if (rd_perr !== 1'b0) begin
      errors++;
      $display("FAIL parity_idle: rd_perr=%b expected 0", rd_perr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clear_readback();
    test_write_read();
    test_write_first();
    test_back_to_back();
    test_out_of_range();
    test_rst_restart();
`ifdef PROG_RAM_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
